// File: rtl/nrisc_pkg.sv
// Shared nRISC definitions: opcodes, instruction field widths and the sequencer state encoding.
package nrisc_pkg;

   localparam int LARG_OP   = 3;
   localparam int LARG_REG  = 3;
   localparam int LARG_BOOL = 2;

   localparam logic [LARG_OP-1:0] OP_NOP  = 3'b000;
   localparam logic [LARG_OP-1:0] OP_ADD  = 3'b001;
   localparam logic [LARG_OP-1:0] OP_SUB  = 3'b010;
   localparam logic [LARG_OP-1:0] OP_AND  = 3'b011;
   localparam logic [LARG_OP-1:0] OP_MOV  = 3'b100;
   localparam logic [LARG_OP-1:0] OP_CMPZ = 3'b101;
   localparam logic [LARG_OP-1:0] OP_BAND = 3'b110;
   localparam logic [LARG_OP-1:0] OP_HALT = 3'b111;

   typedef enum logic [2:0] {
      OCIOSO,
      LEITURA,
      EXECUTA,
      ESCRITA,
      PARADO
   } estado_t;

   // Opcodes whose result lands in the boolean bank rather than the data bank.
   function automatic logic escreveBool(input logic [LARG_OP-1:0] op);
      return (op == OP_CMPZ) || (op == OP_BAND);
   endfunction

endpackage

// File: rtl/ula_nrisc.sv
// Combinational nRISC ALU, zero latency, no flow control: data result for ADD/SUB/AND/MOV,
// boolean result for CMPZ/BAND; carries and borrows wrap modulo 2^LARGURA.
module ula_nrisc
   import nrisc_pkg::*;
#(
   parameter int LARGURA = 8
) (
   input  logic [LARG_OP-1:0]  op,
   input  logic [LARGURA-1:0]  a,
   input  logic [LARGURA-1:0]  b,
   input  logic                ba,
   input  logic                bb,
   output logic [LARGURA-1:0]  resultado,
   output logic                resultado_bool
);

   always_comb begin
      resultado      = '0;
      resultado_bool = 1'b0;
      case (op)
         OP_ADD:  resultado      = a + b;
         OP_SUB:  resultado      = a - b;
         OP_AND:  resultado      = a & b;
         OP_MOV:  resultado      = b;
         OP_CMPZ: resultado_bool = (a == '0);
         OP_BAND: resultado_bool = ba & bb;
         default: ;
      endcase
   end

endmodule

// File: rtl/sequenciador_registradores.sv
// Register-bank sequencer: fetch/read/execute/write, 4 cycles per instruction (3 for NOP);
// InstrPronto only in OCIOSO, Halt freezes every transition and masks the write enables.
module sequenciador_registradores
   import nrisc_pkg::*;
#(
   parameter int LARGURA = 8,
   parameter int NREG    = 8,
   parameter int NBOOL   = 4
) (
   input  logic                     Clock,
   input  logic                     ResetN,
   input  logic                     Halt,
   input  logic [LARGURA-1:0]       Instr,
   input  logic                     InstrValido,
   output logic                     InstrPronto,
   output logic [$clog2(NREG)-1:0]  RegLido1,
   output logic [$clog2(NREG)-1:0]  RegLido2,
   input  logic [LARGURA-1:0]       Dado1,
   input  logic [LARGURA-1:0]       Dado2,
   output logic [$clog2(NBOOL)-1:0] BoolLido1,
   output logic [$clog2(NBOOL)-1:0] BoolLido2,
   input  logic                     DadoBool1,
   input  logic                     DadoBool2,
   output logic [$clog2(NREG)-1:0]  RegEscrito,
   output logic [LARGURA-1:0]       DadoEscrito,
   output logic                     EscritaReg,
   output logic [$clog2(NBOOL)-1:0] BoolEscrito,
   output logic                     DadoBoolEscrito,
   output logic                     EscritaBool,
   output logic                     Parado,
   output logic [7:0]               InstrCount
);

   estado_t              estado;
   logic [LARGURA-1:0]   instrReg;
   logic [LARGURA-1:0]   opA;
   logic [LARGURA-1:0]   opB;
   logic                 boolA;
   logic                 boolB;
   logic                 escritaRegQ;
   logic                 escritaBoolQ;

   logic [LARG_OP-1:0]   op;
   logic [LARG_REG-1:0]  rd;
   logic [LARG_REG-1:0]  rs;
   logic [LARG_REG-1:0]  rCmpz;
   logic [LARG_BOOL-1:0] bd;
   logic [LARG_BOOL-1:0] bs;
   logic [LARGURA-1:0]   resUla;
   logic                 resUlaBool;

   // Fields come from the captured instruction so the producer may change Instr after acceptance.
   assign op    = instrReg[7:5];
   assign rd    = instrReg[4:2];
   assign rs    = {1'b0, instrReg[1:0]};
   assign rCmpz = instrReg[2:0];
   assign bd    = instrReg[4:3];
   assign bs    = instrReg[1:0];

   assign RegLido1  = (op == OP_CMPZ) ? rCmpz : rd;
   assign RegLido2  = rs;
   assign BoolLido1 = bd;
   assign BoolLido2 = bs;

   // The held enable stays armed through a freeze, so the write lands exactly once after release.
   assign EscritaReg  = escritaRegQ  & ~Halt;
   assign EscritaBool = escritaBoolQ & ~Halt;

   ula_nrisc #(
      .LARGURA (LARGURA)
   ) u_ula (
      .op             (op),
      .a              (opA),
      .b              (opB),
      .ba             (boolA),
      .bb             (boolB),
      .resultado      (resUla),
      .resultado_bool (resUlaBool)
   );

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         estado          <= OCIOSO;
         InstrPronto     <= 1'b1;
         Parado          <= 1'b0;
         InstrCount      <= '0;
         instrReg        <= '0;
         opA             <= '0;
         opB             <= '0;
         boolA           <= 1'b0;
         boolB           <= 1'b0;
         RegEscrito      <= '0;
         DadoEscrito     <= '0;
         BoolEscrito     <= '0;
         DadoBoolEscrito <= 1'b0;
         escritaRegQ     <= 1'b0;
         escritaBoolQ    <= 1'b0;
      end else if (!Halt) begin
         case (estado)
            OCIOSO: begin
               if (InstrValido) begin
                  instrReg    <= Instr;
                  InstrPronto <= 1'b0;
                  estado      <= LEITURA;
               end
            end
            LEITURA: begin
               opA    <= Dado1;
               opB    <= Dado2;
               boolA  <= DadoBool1;
               boolB  <= DadoBool2;
               estado <= EXECUTA;
            end
            EXECUTA: begin
               if (op == OP_HALT) begin
                  Parado <= 1'b1;
                  estado <= PARADO;
               end else if (op == OP_NOP) begin
                  InstrCount  <= InstrCount + 8'd1;
                  InstrPronto <= 1'b1;
                  estado      <= OCIOSO;
               end else if (escreveBool(op)) begin
                  BoolEscrito     <= bd;
                  DadoBoolEscrito <= resUlaBool;
                  escritaBoolQ    <= 1'b1;
                  estado          <= ESCRITA;
               end else begin
                  RegEscrito  <= rd;
                  DadoEscrito <= resUla;
                  escritaRegQ <= 1'b1;
                  estado      <= ESCRITA;
               end
            end
            ESCRITA: begin
               escritaRegQ  <= 1'b0;
               escritaBoolQ <= 1'b0;
               InstrCount   <= InstrCount + 8'd1;
               InstrPronto  <= 1'b1;
               estado       <= OCIOSO;
            end
            PARADO: estado <= PARADO;
            default: estado <= OCIOSO;
         endcase
      end
   end

endmodule

// File: tb/tb_sequenciador_registradores.sv
// Directed plus randomized bench for the register sequencer, with a behavioural register-bank
// reference model and an environment bank that answers the DUT read/write ports.
module tb_sequenciador_registradores;

   logic       Clock = 1'b0;
   logic       ResetN;
   logic       Halt;
   logic [7:0] Instr;
   logic       InstrValido;
   logic       InstrPronto;
   logic [2:0] RegLido1, RegLido2;
   logic [7:0] Dado1, Dado2;
   logic [1:0] BoolLido1, BoolLido2;
   logic       DadoBool1, DadoBool2;
   logic [2:0] RegEscrito;
   logic [7:0] DadoEscrito;
   logic       EscritaReg;
   logic [1:0] BoolEscrito;
   logic       DadoBoolEscrito;
   logic       EscritaBool;
   logic       Parado;
   logic [7:0] InstrCount;

   // Environment bank, fed by the DUT write port or by bench preloads while idle.
   logic [7:0] bankR [8];
   logic       bankB [4];
   logic       cargaR, cargaB;
   logic [2:0] cargaEnd;
   logic [7:0] cargaVal;

   // Reference model: architectural state derived from instruction semantics only.
   logic [7:0] refR [8];
   logic       refB [4];
   int         refCount;

   int checks = 0;
   int errors = 0;

   always #5 Clock = ~Clock;

   assign Dado1     = bankR[RegLido1];
   assign Dado2     = bankR[RegLido2];
   assign DadoBool1 = bankB[BoolLido1];
   assign DadoBool2 = bankB[BoolLido2];

   always @(posedge Clock) begin
      if (cargaR) bankR[cargaEnd] <= cargaVal;
      else if (EscritaReg) bankR[RegEscrito] <= DadoEscrito;
      if (cargaB) bankB[cargaEnd[1:0]] <= cargaVal[0];
      else if (EscritaBool) bankB[BoolEscrito] <= DadoBoolEscrito;
   end

   sequenciador_registradores #(
      .LARGURA (8),
      .NREG    (8),
      .NBOOL   (4)
   ) dut (
      .Clock           (Clock),
      .ResetN          (ResetN),
      .Halt            (Halt),
      .Instr           (Instr),
      .InstrValido     (InstrValido),
      .InstrPronto     (InstrPronto),
      .RegLido1        (RegLido1),
      .RegLido2        (RegLido2),
      .Dado1           (Dado1),
      .Dado2           (Dado2),
      .BoolLido1       (BoolLido1),
      .BoolLido2       (BoolLido2),
      .DadoBool1       (DadoBool1),
      .DadoBool2       (DadoBool2),
      .RegEscrito      (RegEscrito),
      .DadoEscrito     (DadoEscrito),
      .EscritaReg      (EscritaReg),
      .BoolEscrito     (BoolEscrito),
      .DadoBoolEscrito (DadoBoolEscrito),
      .EscritaBool     (EscritaBool),
      .Parado          (Parado),
      .InstrCount      (InstrCount)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chkReset(input string t);
      chk({t, " pronto"}, 32'(InstrPronto), 1);
      chk({t, " parado"}, 32'(Parado), 0);
      chk({t, " contador"}, 32'(InstrCount), 0);
      chk({t, " escr_reg"}, 32'(EscritaReg), 0);
      chk({t, " escr_bool"}, 32'(EscritaBool), 0);
      chk({t, " reg_escrito"}, 32'(RegEscrito), 0);
      chk({t, " dado_escrito"}, 32'(DadoEscrito), 0);
      chk({t, " bool_escrito"}, 32'(BoolEscrito), 0);
      chk({t, " dbool_escrito"}, 32'(DadoBoolEscrito), 0);
      chk({t, " lidos"}, {22'd0, RegLido1, RegLido2, BoolLido1, BoolLido2}, 0);
   endtask

   // Called at a falling edge with the bank port idle.
   task automatic carregaR(input int a, input logic [7:0] v);
      cargaR = 1'b1; cargaEnd = 3'(a); cargaVal = v;
      @(negedge Clock);
      cargaR = 1'b0;
      refR[a] = v;
   endtask

   task automatic carregaB(input int a, input logic v);
      cargaB = 1'b1; cargaEnd = 3'(a); cargaVal = {7'd0, v};
      @(negedge Clock);
      cargaB = 1'b0;
      refB[a] = v;
   endtask

   // Offers one instruction at cycle 0 and holds Halt high during cycles [hIni, hIni+hLen).
   task automatic executa(input logic [7:0] ins, input int hIni, input int hLen);
      logic [2:0] op, rd, rs;
      logic [1:0] bd, bs;
      logic [7:0] expDat;
      logic       expBit;
      bit         expW, ehBool, aceito, wHalt, wReg, wBool;
      int         expRet, budget, nWr, wrCyc, retCyc;
      logic [2:0] wAddr;
      logic [7:0] wDat;
      logic [1:0] wBAddr;
      logic       wBDat;
      string      t;

      t = $sformatf("ins%02h h%0d/%0d", ins, hIni, hLen);
      op = ins[7:5]; rd = ins[4:2]; rs = {1'b0, ins[1:0]}; bd = ins[4:3]; bs = ins[1:0];
      expW = 1'b1; ehBool = 1'b0; expDat = 8'd0; expBit = 1'b0;
      case (op)
         3'd1: expDat = refR[rd] + refR[rs];
         3'd2: expDat = refR[rd] - refR[rs];
         3'd3: expDat = refR[rd] & refR[rs];
         3'd4: expDat = refR[rs];
         3'd5: begin ehBool = 1'b1; expBit = (refR[ins[2:0]] == 8'd0); end
         3'd6: begin ehBool = 1'b1; expBit = refB[bd] & refB[bs]; end
         default: expW = 1'b0;
      endcase
      if (expW && !ehBool) refR[rd] = expDat;
      if (ehBool) refB[bd] = expBit;
      if (op != 3'd7) refCount++;
      expRet = (op == 3'd7) ? -1 : (op == 3'd0) ? 3 + hLen : 4 + hLen;
      budget = 7 + hLen;

      aceito = 0; wHalt = 0; wReg = 0; wBool = 0;
      nWr = 0; wrCyc = -1; retCyc = -1;
      wAddr = '0; wDat = '0; wBAddr = '0; wBDat = 1'b0;
      chk({t, " pronto_ini"}, 32'(InstrPronto), 1);
      for (int c = 0; c < budget; c++) begin
         if (!aceito && c > 0 && !InstrPronto) aceito = 1;
         Instr = ins;
         InstrValido = !aceito;
         Halt = (c >= hIni) && (c < hIni + hLen);
         #1;
         if (EscritaReg || EscritaBool) begin
            nWr++;
            if (Halt) wHalt = 1;
            if (wrCyc < 0) begin
               wrCyc = c; wReg = EscritaReg; wBool = EscritaBool;
               wAddr = RegEscrito; wDat = DadoEscrito;
               wBAddr = BoolEscrito; wBDat = DadoBoolEscrito;
            end
         end
         if (aceito && InstrPronto && retCyc < 0) retCyc = c;
         @(negedge Clock);
      end
      Halt = 1'b0;
      InstrValido = 1'b0;

      chk({t, " n_escritas"}, nWr, expW ? 1 : 0);
      if (expW) begin
         chk({t, " ciclo_escrita"}, wrCyc, 3 + hLen);
         chk({t, " en_reg"}, 32'(wReg), 32'(!ehBool));
         chk({t, " en_bool"}, 32'(wBool), 32'(ehBool));
         if (ehBool) begin
            chk({t, " bool_end"}, 32'(wBAddr), 32'(bd));
            chk({t, " bool_dado"}, 32'(wBDat), 32'(expBit));
         end else begin
            chk({t, " reg_end"}, 32'(wAddr), 32'(rd));
            chk({t, " reg_dado"}, 32'(wDat), 32'(expDat));
         end
      end
      chk({t, " escrita_sob_halt"}, 32'(wHalt), 0);
      chk({t, " retorno_pronto"}, retCyc, expRet);
      chk({t, " contador"}, 32'(InstrCount), 32'(refCount[7:0]));
      chk({t, " parado"}, 32'(Parado), 32'(op == 3'd7));
   endtask

   // Holds InstrValido high and measures the spacing between acceptances.
   task automatic rajada(input logic [7:0] ins, input int n, input int gap, input int budget);
      int nAcc, last, badGap, c;
      nAcc = 0; last = -1; badGap = 0; c = 0;
      Instr = ins;
      InstrValido = 1'b1;
      while (c < budget && !(nAcc == n && InstrPronto)) begin
         if (InstrPronto) begin
            if (last >= 0 && c - last != gap) badGap++;
            last = c;
            nAcc++;
         end
         @(negedge Clock);
         c++;
      end
      InstrValido = 1'b0;
      chk($sformatf("rajada%02h aceites", ins), nAcc, n);
      chk($sformatf("rajada%02h intervalo", ins), badGap, 0);
      chk($sformatf("rajada%02h prazo", ins), 32'(c < budget), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] iniR [8];
      logic [7:0] ins;
      int hi, hl, n;

      iniR = '{8'h00, 8'h10, 8'h05, 8'h01, 8'hF0, 8'h00, 8'h33, 8'h7E};
      ResetN = 1'b1; Halt = 1'b0; InstrValido = 1'b0; Instr = 8'h00;
      cargaR = 1'b0; cargaB = 1'b0; cargaEnd = 3'd0; cargaVal = 8'd0;
      refCount = 0;
      #1 ResetN = 1'b0;
      repeat (2) @(negedge Clock);
      ResetN = 1'b1;
      #1 chkReset("reset");
      @(negedge Clock);

      for (int i = 0; i < 8; i++) carregaR(i, iniR[i]);
      carregaB(0, 1'b1); carregaB(1, 1'b0); carregaB(2, 1'b1); carregaB(3, 1'b0);

      executa(8'h26, 0, 0);            // ADD r1,r2: 0x10+0x05
      executa(8'h43, 0, 0);            // SUB r0,r3: 0x00-0x01 wraps
      carregaR(2, 8'h20);
      executa(8'h32, 0, 0);            // ADD r4,r2: 0xF0+0x20 wraps
      executa(8'hB5, 0, 0);            // CMPZ b2 <- r5==0
      executa(8'hD1, 0, 0);            // BAND b2,b1 with b1=0
      executa(8'h6D, 3, 5);            // AND r3,r1 frozen in the write cycle
      executa(8'h9C, 0, 2);            // MOV r7,r0 offered while frozen

      rajada(8'h25, 5, 4, 40);         // ADD r1,r1 back to back
      for (int i = 0; i < 5; i++) refR[1] = refR[1] + refR[1];
      refCount += 5;
      chk("rajada contador", 32'(InstrCount), 32'(refCount[7:0]));
      chk("rajada r1", 32'(bankR[1]), 32'(refR[1]));

      for (int k = 0; k < 16; k++) begin
         carregaR($urandom_range(0, 7), ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom));
         carregaB($urandom_range(0, 3), 1'($urandom));
         ins = 8'($urandom_range(0, 8'hDF));
         hi = (ins[7:5] == 3'd0) ? $urandom_range(0, 2) : $urandom_range(0, 3);
         hl = $urandom_range(0, 3);
         executa(ins, hi, hl);
      end

      executa(8'hE0, 0, 0);            // HALT
      Instr = 8'h26; InstrValido = 1'b1; n = 0;
      repeat (5) begin
         @(negedge Clock);
         if (InstrPronto || EscritaReg || EscritaBool) n++;
      end
      InstrValido = 1'b0;
      chk("parado ignora", n, 0);
      chk("parado contador", 32'(InstrCount), 32'(refCount[7:0]));
      chk("parado flag", 32'(Parado), 1);

      ResetN = 1'b0;
      #2 chkReset("reset_parado");
      @(negedge Clock);
      ResetN = 1'b1;
      refCount = 0;

      Instr = 8'h26; InstrValido = 1'b1;
      @(posedge Clock);
      @(negedge Clock);
      InstrValido = 1'b0;
      chk("aborto aceito", 32'(InstrPronto), 0);
      #2 ResetN = 1'b0;
      #1 chkReset("reset_aborto");
      #1 ResetN = 1'b1;
      n = 0;
      repeat (6) begin
         @(negedge Clock);
         if (EscritaReg || EscritaBool || !InstrPronto) n++;
      end
      chk("aborto sem escrita", n, 0);

      rajada(8'h00, 256, 3, 800);      // NOP count wraps back to zero
      refCount += 256;
      chk("nop contador volta", 32'(InstrCount), 32'(refCount[7:0]));

      executa(8'h26, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
